// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, branch types, memory-control
// bit positions and the ID/EXE control bundle.
package exe_pkg;

   localparam logic [3:0] EXE_ADD = 4'b0000;
   localparam logic [3:0] EXE_SUB = 4'b0010;
   localparam logic [3:0] EXE_AND = 4'b0100;
   localparam logic [3:0] EXE_OR  = 4'b0101;
   localparam logic [3:0] EXE_NOR = 4'b0110;
   localparam logic [3:0] EXE_XOR = 4'b0111;
   localparam logic [3:0] EXE_SLL = 4'b1000;
   localparam logic [3:0] EXE_SRA = 4'b1001;
   localparam logic [3:0] EXE_SRL = 4'b1010;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_BEZ  = 2'b01;
   localparam logic [1:0] BR_BNE  = 2'b10;
   localparam logic [1:0] BR_JMP  = 2'b11;

   localparam int MEM_R_BIT = 1;
   localparam int MEM_W_BIT = 0;

   localparam int CMD_W  = 4;
   localparam int BR_W   = 2;
   localparam int MSIG_W = 2;
   localparam int CTRL_W = 1 + MSIG_W + BR_W + CMD_W;

   typedef struct packed {
      logic              wb_en;
      logic [MSIG_W-1:0] mem_sig;
      logic [BR_W-1:0]   br_type;
      logic [CMD_W-1:0]  cmd;
   } ctrl_t;

   // An all-zero control word never writes, loads, stores or branches.
   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU for the execute stage; unknown opcodes yield zero.
module alu
   import exe_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0]    op1,
   input  logic [DW-1:0]    op2,
   input  logic [CMD_W-1:0] cmd,
   output logic [DW-1:0]    result
);

   logic signed [DW-1:0] op1_s;
   logic [4:0]           shamt;

   assign op1_s = op1;
   assign shamt = op2[4:0];

   always_comb begin
      result = '0;
      case (cmd)
         EXE_ADD: result = op1 + op2;
         EXE_SUB: result = op1 - op2;
         EXE_AND: result = op1 & op2;
         EXE_OR:  result = op1 | op2;
         EXE_NOR: result = ~(op1 | op2);
         EXE_XOR: result = op1 ^ op2;
         EXE_SLL: result = op1 << shamt;
         EXE_SRA: result = op1_s >>> shamt;
         EXE_SRL: result = op1 >> shamt;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ID/EXE register, ALU, branch resolution and EXE/MEM register.
// Defining EXE_FWD_EN adds MEM/WB operand forwarding and its ports.
module exe_stage
   import exe_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          freeze,
   input  logic          WB_En_in,
   input  logic [1:0]    MEM_Signal,
   input  logic [1:0]    Branch_Type,
   input  logic [3:0]    EXE_CMD,
   input  logic [DW-1:0] val1,
   input  logic [DW-1:0] val2,
   input  logic [DW-1:0] reg2,
   input  logic [DW-1:0] PC_in,
   input  logic [RW-1:0] dest_in,
`ifdef EXE_FWD_EN
   input  logic [RW-1:0] src1,
   input  logic [RW-1:0] src2,
   input  logic          is_imm,
   input  logic          MEM_WB_En,
   input  logic [RW-1:0] MEM_Dest,
   input  logic [DW-1:0] MEM_Result,
   input  logic          WB_WB_En,
   input  logic [RW-1:0] WB_Dest,
   input  logic [DW-1:0] WB_Data,
`endif
   output logic          BrTaken,
   output logic [DW-1:0] Br_Addr,
   output logic          WB_En_out,
   output logic          MEM_R_EN,
   output logic          MEM_W_EN,
   output logic [DW-1:0] ALU_Result,
   output logic [DW-1:0] ST_Val,
   output logic [RW-1:0] Dest
);

   ctrl_t         ctrl_d, ctrl_q;
   logic [DW-1:0] val1_q, val2_q, reg2_q, pc_q;
   logic [RW-1:0] dest_q;
   logic [DW-1:0] op1, op2, st_val, alu_res;
   logic          br_taken;
   logic          wb_q, mem_r_q, mem_w_q;
   logic [DW-1:0] res_q, st_q;
   logic [RW-1:0] dst_q;

   // A taken branch replaces the wrong-path ID instruction with a bubble.
   always_comb begin
      ctrl_d = '{wb_en: WB_En_in, mem_sig: MEM_Signal, br_type: Branch_Type, cmd: EXE_CMD};
      if (br_taken) ctrl_d = CTRL_BUBBLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q <= CTRL_BUBBLE;
         val1_q <= '0;
         val2_q <= '0;
         reg2_q <= '0;
         pc_q   <= '0;
         dest_q <= '0;
      end else if (!freeze) begin
         ctrl_q <= ctrl_d;
         val1_q <= val1;
         val2_q <= val2;
         reg2_q <= reg2;
         pc_q   <= PC_in;
         dest_q <= dest_in;
      end
   end

`ifdef EXE_FWD_EN
   logic [RW-1:0] src1_q, src2_q;
   logic          is_imm_q;

   function automatic logic [DW-1:0] fwd(input logic [RW-1:0] src, input logic [DW-1:0] rv,
                                         input logic m_en, input logic [RW-1:0] m_dst,
                                         input logic [DW-1:0] m_val, input logic w_en,
                                         input logic [RW-1:0] w_dst, input logic [DW-1:0] w_val);
      if (src != '0 && m_en && m_dst == src) return m_val;
      if (src != '0 && w_en && w_dst == src) return w_val;
      return rv;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src1_q   <= '0;
         src2_q   <= '0;
         is_imm_q <= 1'b0;
      end else if (!freeze) begin
         src1_q   <= src1;
         src2_q   <= src2;
         is_imm_q <= is_imm;
      end
   end

   always_comb begin
      op1    = fwd(src1_q, val1_q, MEM_WB_En, MEM_Dest, MEM_Result, WB_WB_En, WB_Dest, WB_Data);
      st_val = fwd(src2_q, reg2_q, MEM_WB_En, MEM_Dest, MEM_Result, WB_WB_En, WB_Dest, WB_Data);
      op2    = is_imm_q ? val2_q
                        : fwd(src2_q, val2_q, MEM_WB_En, MEM_Dest, MEM_Result, WB_WB_En, WB_Dest, WB_Data);
   end
`else
   always_comb begin
      op1    = val1_q;
      op2    = val2_q;
      st_val = reg2_q;
   end
`endif

   alu #(.DW(DW)) u_alu (
      .op1    (op1),
      .op2    (op2),
      .cmd    (ctrl_q.cmd),
      .result (alu_res)
   );

   always_comb begin
      br_taken = 1'b0;
      case (ctrl_q.br_type)
         BR_BEZ:  br_taken = (op1 == '0);
         BR_BNE:  br_taken = (op1 != st_val);
         BR_JMP:  br_taken = 1'b1;
         default: br_taken = 1'b0;
      endcase
   end

   assign BrTaken = br_taken;
   assign Br_Addr = pc_q + (op2 << 2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_q    <= 1'b0;
         mem_r_q <= 1'b0;
         mem_w_q <= 1'b0;
         res_q   <= '0;
         st_q    <= '0;
         dst_q   <= '0;
      end else if (!freeze) begin
         wb_q    <= ctrl_q.wb_en;
         mem_r_q <= ctrl_q.mem_sig[MEM_R_BIT];
         mem_w_q <= ctrl_q.mem_sig[MEM_W_BIT];
         res_q   <= alu_res;
         st_q    <= st_val;
         dst_q   <= dest_q;
      end
   end

   assign WB_En_out  = wb_q;
   assign MEM_R_EN   = mem_r_q;
   assign MEM_W_EN   = mem_w_q;
   assign ALU_Result = res_q;
   assign ST_Val     = st_q;
   assign Dest       = dst_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: ALU table, randomized stream vs. reference model,
// and directed branch / freeze / reset sequences (forwarding cases when EXE_FWD_EN is defined).
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze = 1'b0;
   logic        WB_En_in;
   logic [1:0]  MEM_Signal, Branch_Type;
   logic [3:0]  EXE_CMD;
   logic [31:0] val1, val2, reg2, PC_in;
   logic [4:0]  dest_in;
   logic        BrTaken, WB_En_out, MEM_R_EN, MEM_W_EN;
   logic [31:0] Br_Addr, ALU_Result, ST_Val;
   logic [4:0]  Dest;
`ifdef EXE_FWD_EN
   logic [4:0]  src1 = '0, src2 = '0, MEM_Dest = '0, WB_Dest = '0;
   logic        is_imm = 1'b1, MEM_WB_En = 1'b0, WB_WB_En = 1'b0;
   logic [31:0] MEM_Result = '0, WB_Data = '0;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   exe_stage dut (
      .clk(clk), .rst(rst), .freeze(freeze), .WB_En_in(WB_En_in), .MEM_Signal(MEM_Signal),
      .Branch_Type(Branch_Type), .EXE_CMD(EXE_CMD), .val1(val1), .val2(val2), .reg2(reg2),
      .PC_in(PC_in), .dest_in(dest_in),
`ifdef EXE_FWD_EN
      .src1(src1), .src2(src2), .is_imm(is_imm), .MEM_WB_En(MEM_WB_En), .MEM_Dest(MEM_Dest),
      .MEM_Result(MEM_Result), .WB_WB_En(WB_WB_En), .WB_Dest(WB_Dest), .WB_Data(WB_Data),
`endif
      .BrTaken(BrTaken), .Br_Addr(Br_Addr), .WB_En_out(WB_En_out), .MEM_R_EN(MEM_R_EN),
      .MEM_W_EN(MEM_W_EN), .ALU_Result(ALU_Result), .ST_Val(ST_Val), .Dest(Dest)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic wb, input logic [1:0] ms, input logic [1:0] bt,
                        input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r2, input logic [31:0] pc, input logic [4:0] d);
      WB_En_in = wb; MEM_Signal = ms; Branch_Type = bt; EXE_CMD = cmd;
      val1 = a; val2 = b; reg2 = r2; PC_in = pc; dest_in = d;
   endtask

   task automatic nop();
      drive(1'b0, 2'b00, 2'b00, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
   endtask

   // Reference ALU from the opcode table, using plain arithmetic.
   function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned s;
      logic [31:0] r;
      s = b % 32;
      case (cmd)
         4'b0000: return a + b;
         4'b0010: return a - b;
         4'b0100: return a & b;
         4'b0101: return a | b;
         4'b0110: return ~(a | b);
         4'b0111: return a ^ b;
         4'b1000: return a * (32'd1 << s);
         4'b1001: begin
            r = a / (32'd1 << s);
            if (a[31]) r = r | ~(32'hFFFF_FFFF / (32'd1 << s));
            return r;
         end
         4'b1010: return a / (32'd1 << s);
         default: return 32'h0;
      endcase
   endfunction

   typedef struct {
      logic [3:0]  cmd;
      logic [31:0] a, b, exp;
   } alu_vec_t;

   typedef struct {
      logic [31:0] res, st;
      logic [4:0]  dst;
      logic        wb, mr, mw;
   } exp_t;

   alu_vec_t tv[12];
   exp_t     q[$];
   exp_t     e;

   initial begin
      logic [31:0] a, b, r2, pc, ba_prev;
      logic [3:0]  cmd;
      logic [1:0]  ms;
      logic        wb;
      logic [4:0]  d;

      tv[0]  = '{4'b0000, 32'd5,          32'd7,          32'd12};
      tv[1]  = '{4'b0010, 32'd0,          32'd1,          32'hFFFF_FFFF};
      tv[2]  = '{4'b1001, 32'h8000_0000,  32'd4,          32'hF800_0000};
      tv[3]  = '{4'b0100, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000};
      tv[4]  = '{4'b0101, 32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF};
      tv[5]  = '{4'b0110, 32'h0,          32'h0,          32'hFFFF_FFFF};
      tv[6]  = '{4'b0111, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555};
      tv[7]  = '{4'b1000, 32'd1,          32'd31,         32'h8000_0000};
      tv[8]  = '{4'b1010, 32'h8000_0000,  32'd4,          32'h0800_0000};
      tv[9]  = '{4'b1000, 32'd1,          32'h23,         32'd8};
      tv[10] = '{4'b0001, 32'd5,          32'd7,          32'd0};
      tv[11] = '{4'b0000, 32'hFFFF_FFFF,  32'd2,          32'd1};

      // Reset holds everything at zero even with a live instruction on the inputs.
      drive(1'b1, 2'b11, 2'b11, 4'h0, 32'd5, 32'd7, 32'd9, 32'h40, 5'd3);
      @(negedge clk); @(negedge clk);
      chk("rst_outputs", {BrTaken, WB_En_out, MEM_R_EN, MEM_W_EN, 23'd0, Dest}, 32'h0);
      chk("rst_alu", ALU_Result, 32'h0);
      chk("rst_st", ST_Val, 32'h0);
      chk("rst_braddr", Br_Addr, 32'h0);
      nop();
      rst = 1'b0;
      @(negedge clk);

      foreach (tv[i]) begin
         drive(1'b1, 2'b00, 2'b00, tv[i].cmd, tv[i].a, tv[i].b, 32'h0, 32'h0, 5'd3);
         @(negedge clk); @(negedge clk);
         chk($sformatf("alu_tbl[%0d]", i), ALU_Result, tv[i].exp);
         if (i == 0) begin
            chk("add_dest", {27'd0, Dest}, 32'd3);
            chk("add_wb", {31'd0, WB_En_out}, 32'd1);
         end
      end

      // Randomized non-branch stream, fully pipelined.
      ba_prev = 32'h0;
      for (int i = 0; i < 202; i++) begin
         if (i >= 2) begin
            e = q.pop_front();
            chk("rnd_res", ALU_Result, e.res);
            chk("rnd_st", ST_Val, e.st);
            chk("rnd_ctl", {24'd0, WB_En_out, MEM_R_EN, MEM_W_EN, Dest},
                {24'd0, e.wb, e.mr, e.mw, e.dst});
         end
         if (i >= 1 && i <= 200) begin
            chk("rnd_braddr", Br_Addr, ba_prev);
            chk("rnd_brtaken", {31'd0, BrTaken}, 32'd0);
         end
         if (i < 200) begin
            cmd = 4'($urandom_range(0, 15));
            a = $urandom; b = $urandom; r2 = $urandom; pc = $urandom;
            if ($urandom_range(0, 1) == 1) b = b % 40;
            wb = 1'($urandom); ms = 2'($urandom); d = 5'($urandom);
            drive(wb, ms, 2'b00, cmd, a, b, r2, pc, d);
            e.res = ref_alu(cmd, a, b); e.st = r2; e.dst = d;
            e.wb = wb; e.mr = ms[1]; e.mw = ms[0];
            q.push_back(e);
            ba_prev = pc + b * 4;
         end else begin
            nop();
         end
         @(negedge clk);
      end

      // BNE taken: one-cycle pulse, wrong-path instruction flushed.
      nop(); @(negedge clk); @(negedge clk);
      drive(1'b0, 2'b00, 2'b10, 4'h0, 32'd1, 32'd3, 32'd2, 32'h100, 5'd0);
      @(negedge clk);
      chk("bne_taken", {31'd0, BrTaken}, 32'd1);
      chk("bne_addr", Br_Addr, 32'h10C);
      drive(1'b1, 2'b00, 2'b00, 4'h0, 32'd1, 32'd1, 32'd0, 32'h104, 5'd7);
      @(negedge clk);
      chk("bne_pulse_end", {31'd0, BrTaken}, 32'd0);
      nop();
      @(negedge clk);
      chk("bne_flush_wb", {31'd0, WB_En_out}, 32'd0);

      // BNE not taken (equal operands), BEZ taken/not taken.
      drive(1'b0, 2'b00, 2'b10, 4'h0, 32'd6, 32'd1, 32'd6, 32'h20, 5'd0);
      @(negedge clk);
      chk("bne_equal", {31'd0, BrTaken}, 32'd0);
      drive(1'b0, 2'b00, 2'b01, 4'h0, 32'd0, 32'd2, 32'd0, 32'h40, 5'd0);
      @(negedge clk);
      chk("bez_zero", {31'd0, BrTaken}, 32'd1);
      chk("bez_addr", Br_Addr, 32'h48);
      drive(1'b0, 2'b00, 2'b01, 4'h0, 32'd1, 32'd2, 32'd0, 32'h40, 5'd0);
      @(negedge clk);
      chk("bez_flushed", {31'd0, BrTaken}, 32'd0);
      @(negedge clk);
      chk("bez_nonzero", {31'd0, BrTaken}, 32'd0);

      // JMP under a 3-cycle freeze.
      nop(); @(negedge clk); @(negedge clk);
      drive(1'b1, 2'b00, 2'b00, 4'h0, 32'd20, 32'd22, 32'd0, 32'h0, 5'd5);
      @(negedge clk);
      drive(1'b0, 2'b00, 2'b11, 4'h0, 32'd0, 32'd4, 32'd0, 32'h200, 5'd0);
      @(negedge clk);
      chk("jmp_taken", {31'd0, BrTaken}, 32'd1);
      chk("jmp_addr", Br_Addr, 32'h210);
      chk("jmp_prev_res", ALU_Result, 32'd42);
      freeze = 1'b1;
      drive(1'b1, 2'b00, 2'b00, 4'h0, 32'd1, 32'd1, 32'd0, 32'h204, 5'd9);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("frz_taken[%0d]", k), {31'd0, BrTaken}, 32'd1);
         chk($sformatf("frz_hold[%0d]", k), {ALU_Result[25:0], WB_En_out, Dest}, {26'd42, 1'b1, 5'd5});
      end
      freeze = 1'b0;
      @(negedge clk);
      chk("frz_release_taken", {31'd0, BrTaken}, 32'd0);
      chk("frz_release_res", ALU_Result, 32'd4);
      chk("frz_release_wb", {31'd0, WB_En_out}, 32'd0);
      nop();
      @(negedge clk);
      chk("frz_flush_wb", {31'd0, WB_En_out}, 32'd0);

`ifdef EXE_FWD_EN
      // Forwarding priority: MEM over WB over register; source 0 is never forwarded.
      src1 = 5'd4; is_imm = 1'b1;
      MEM_WB_En = 1'b1; MEM_Dest = 5'd4; MEM_Result = 32'd9;
      WB_WB_En = 1'b1; WB_Dest = 5'd4; WB_Data = 32'd1;
      drive(1'b1, 2'b00, 2'b00, 4'h0, 32'd0, 32'd1, 32'd0, 32'h0, 5'd2);
      @(negedge clk); @(negedge clk);
      chk("fwd_mem_wins", ALU_Result, 32'd10);
      MEM_WB_En = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("fwd_wb", ALU_Result, 32'd2);
      MEM_WB_En = 1'b1; src1 = 5'd0;
      @(negedge clk); @(negedge clk);
      chk("fwd_src0", ALU_Result, 32'd1);
      MEM_WB_En = 1'b0; WB_WB_En = 1'b0;
      nop();
      @(negedge clk); @(negedge clk);
`endif

      // Asynchronous reset while stores are in flight.
      drive(1'b0, 2'b01, 2'b00, 4'h0, 32'd100, 32'd4, 32'hDEAD, 32'h0, 5'd0);
      @(negedge clk);
      drive(1'b0, 2'b01, 2'b00, 4'h0, 32'd200, 32'd8, 32'hBEEF, 32'h0, 5'd0);
      @(negedge clk);
      chk("st_memw", {31'd0, MEM_W_EN}, 32'd1);
      chk("st_addr", ALU_Result, 32'd104);
      chk("st_val", ST_Val, 32'hDEAD);
      nop();
      #2 rst = 1'b1;
      #1;
      chk("arst_memw", {31'd0, MEM_W_EN}, 32'd0);
      chk("arst_res", ALU_Result, 32'd0);
      chk("arst_st", ST_Val, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("arst_after[%0d]", k), {30'd0, MEM_W_EN, WB_En_out}, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
